// File: rtl/mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_arbiter                                                                |
// | Round-robin two-port arbiter for the single data port of the memory block. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module mem_arbiter #(
   parameter int AW = 32,
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          m0_req,
   input  logic [2:0]    m0_we,
   input  logic [AW-1:0] m0_addr,
   input  logic [DW-1:0] m0_wdata,
   output logic          m0_gnt,
   output logic          m0_rvalid,
   output logic [DW-1:0] m0_rdata,
   input  logic          m1_req,
   input  logic [2:0]    m1_we,
   input  logic [AW-1:0] m1_addr,
   input  logic [DW-1:0] m1_wdata,
   output logic          m1_gnt,
   output logic          m1_rvalid,
   output logic [DW-1:0] m1_rdata,
   output logic [2:0]    mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_RESP   = 2'd2
   } state_t;

   state_t        r_state,     w_state_nxt;
   logic          r_last,      w_last_nxt;
   logic          r_win,       w_win_nxt;
   logic [2:0]    r_mem_we,    w_mem_we_nxt;
   logic [AW-1:0] r_mem_addr,  w_mem_addr_nxt;
   logic [DW-1:0] r_mem_wdata, w_mem_wdata_nxt;
   logic          r_gnt0,      w_gnt0_nxt;
   logic          r_gnt1,      w_gnt1_nxt;
   logic          r_rvalid0,   w_rvalid0_nxt;
   logic          r_rvalid1,   w_rvalid1_nxt;
   logic [DW-1:0] r_rdata0,    w_rdata0_nxt;
   logic [DW-1:0] r_rdata1,    w_rdata1_nxt;

   logic          w_pick1;
   logic [2:0]    w_sel_we;
   logic [AW-1:0] w_sel_addr;
   logic [DW-1:0] w_sel_wdata;

   // Malformed enables degrade to a read so a bad requester can never corrupt memory.
   function automatic logic [2:0] f_clean_we(input logic [2:0] we);
      logic [2:0] res;
      case (we)
         3'b100, 3'b010, 3'b001: res = we;
         default:                res = 3'b000;
      endcase
      return res;
   endfunction

   // r_last = 1 means port 1 won last, so port 0 takes a tie.
   assign w_pick1     = m1_req & (~m0_req | ~r_last);
   assign w_sel_we    = w_pick1 ? m1_we    : m0_we;
   assign w_sel_addr  = w_pick1 ? m1_addr  : m0_addr;
   assign w_sel_wdata = w_pick1 ? m1_wdata : m0_wdata;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_last      <= 1'b1;
         r_win       <= 1'b0;
         r_mem_we    <= 3'b000;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_gnt0      <= 1'b0;
         r_gnt1      <= 1'b0;
         r_rvalid0   <= 1'b0;
         r_rvalid1   <= 1'b0;
         r_rdata0    <= '0;
         r_rdata1    <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_last      <= w_last_nxt;
         r_win       <= w_win_nxt;
         r_mem_we    <= w_mem_we_nxt;
         r_mem_addr  <= w_mem_addr_nxt;
         r_mem_wdata <= w_mem_wdata_nxt;
         r_gnt0      <= w_gnt0_nxt;
         r_gnt1      <= w_gnt1_nxt;
         r_rvalid0   <= w_rvalid0_nxt;
         r_rvalid1   <= w_rvalid1_nxt;
         r_rdata0    <= w_rdata0_nxt;
         r_rdata1    <= w_rdata1_nxt;
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_last_nxt      = r_last;
      w_win_nxt       = r_win;
      w_mem_we_nxt    = 3'b000;
      w_mem_addr_nxt  = r_mem_addr;
      w_mem_wdata_nxt = r_mem_wdata;
      w_gnt0_nxt      = 1'b0;
      w_gnt1_nxt      = 1'b0;
      w_rvalid0_nxt   = 1'b0;
      w_rvalid1_nxt   = 1'b0;
      w_rdata0_nxt    = r_rdata0;
      w_rdata1_nxt    = r_rdata1;
      case (r_state)
         S_IDLE: begin
            if (m0_req || m1_req) begin
               w_state_nxt     = S_ACCESS;
               w_win_nxt       = w_pick1;
               w_last_nxt      = w_pick1;
               w_mem_we_nxt    = f_clean_we(w_sel_we);
               w_mem_addr_nxt  = w_sel_addr;
               w_mem_wdata_nxt = w_sel_wdata;
               w_gnt0_nxt      = ~w_pick1;
               w_gnt1_nxt      = w_pick1;
            end
         end
         S_ACCESS: begin
            w_state_nxt = S_RESP;
         end
         S_RESP: begin
            // Memory output is valid now; capture it for the winner only.
            w_state_nxt = S_IDLE;
            if (r_win) begin
               w_rdata1_nxt  = mem_rdata;
               w_rvalid1_nxt = 1'b1;
            end else begin
               w_rdata0_nxt  = mem_rdata;
               w_rvalid0_nxt = 1'b1;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   assign m0_gnt    = r_gnt0;
   assign m1_gnt    = r_gnt1;
   assign m0_rvalid = r_rvalid0;
   assign m1_rvalid = r_rvalid1;
   assign m0_rdata  = r_rdata0;
   assign m1_rdata  = r_rdata1;
   assign mem_we    = r_mem_we;
   assign mem_addr  = r_mem_addr;
   assign mem_wdata = r_mem_wdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mem_arbiter                                                             |
// | Directed vector bench for mem_arbiter with a small behavioural memory.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_mem_arbiter;

   logic        clk;
   logic        rst;
   logic        m0_req, m1_req;
   logic [2:0]  m0_we, m1_we;
   logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
   logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
   logic [31:0] m0_rdata, m1_rdata;
   logic [2:0]  mem_we;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;

   int checks = 0;
   int errors = 0;
   logic [31:0] exp_rd0, exp_rd1;

   typedef struct {
      logic        port;
      logic [2:0]  we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [2:0]  exp_we;
      logic [31:0] exp_rdata;
   } vec_t;

   vec_t vecs [8];
   logic [31:0] mem_model [256];

   mem_arbiter #(.AW(32), .DW(32)) dut (
      .clk(clk), .rst(rst),
      .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
      .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Registered-output memory: read returns the pre-write word, writes commit at the edge.
   always @(posedge clk) begin
      case (mem_we)
         3'b001: mem_model[mem_addr[9:2]] <= mem_wdata;
         3'b010: begin
            if (mem_addr[1]) mem_model[mem_addr[9:2]][31:16] <= mem_wdata[15:0];
            else             mem_model[mem_addr[9:2]][15:0]  <= mem_wdata[15:0];
         end
         3'b100: mem_model[mem_addr[9:2]][8*mem_addr[1:0] +: 8] <= mem_wdata[7:0];
         default: ;
      endcase
      mem_rdata <= mem_model[mem_addr[9:2]];
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One single-requester access starting in an IDLE cycle.
   task automatic do_access(input vec_t v);
      if (v.port) begin
         m1_req = 1'b1; m1_we = v.we; m1_addr = v.addr; m1_wdata = v.wdata;
      end else begin
         m0_req = 1'b1; m0_we = v.we; m0_addr = v.addr; m0_wdata = v.wdata;
      end
      tick();
      chk("acc_gnt", {62'd0, m1_gnt, m0_gnt}, v.port ? 64'd2 : 64'd1);
      chk("acc_mem_we", {61'd0, mem_we}, {61'd0, v.exp_we});
      chk("acc_mem_addr", {32'd0, mem_addr}, {32'd0, v.addr});
      chk("acc_mem_wdata", {32'd0, mem_wdata}, {32'd0, v.wdata});
      m0_req = 1'b0; m1_req = 1'b0;
      tick();
      chk("resp_quiet", {59'd0, mem_we, m1_gnt, m0_gnt}, 64'd0);
      tick();
      if (v.port) exp_rd1 = v.exp_rdata;
      else        exp_rd0 = v.exp_rdata;
      chk("rvalid", {62'd0, m1_rvalid, m0_rvalid}, v.port ? 64'd2 : 64'd1);
      chk("rdata0", {32'd0, m0_rdata}, {32'd0, exp_rd0});
      chk("rdata1", {32'd0, m1_rdata}, {32'd0, exp_rd1});
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t rd300;
      for (int i = 0; i < 256; i++) mem_model[i] = 32'hA5A5_0000 | i;
      vecs[0] = '{1'b0, 3'b001, 32'h100, 32'hDEAD_BEEF, 3'b001, 32'hA5A5_0040};
      vecs[1] = '{1'b0, 3'b000, 32'h100, 32'h0,         3'b000, 32'hDEAD_BEEF};
      vecs[2] = '{1'b1, 3'b011, 32'h200, 32'h1234_5678, 3'b000, 32'hA5A5_0080};
      vecs[3] = '{1'b0, 3'b000, 32'h200, 32'h0,         3'b000, 32'hA5A5_0080};
      vecs[4] = '{1'b1, 3'b100, 32'h204, 32'h0000_00CC, 3'b100, 32'hA5A5_0081};
      vecs[5] = '{1'b1, 3'b000, 32'h204, 32'h0,         3'b000, 32'hA5A5_00CC};
      vecs[6] = '{1'b1, 3'b010, 32'h208, 32'h0000_BEEF, 3'b010, 32'hA5A5_0082};
      vecs[7] = '{1'b0, 3'b111, 32'h208, 32'h0,         3'b000, 32'hA5A5_BEEF};
      rd300   = '{1'b0, 3'b000, 32'h300, 32'h0,         3'b000, 32'hA5A5_00C0};

      rst = 1'b1;
      m0_req = 1'b0; m0_we = 3'b000; m0_addr = 32'h0; m0_wdata = 32'h0;
      m1_req = 1'b0; m1_we = 3'b000; m1_addr = 32'h0; m1_wdata = 32'h0;
      exp_rd0 = 32'h0; exp_rd1 = 32'h0;
      tick(); tick();
      chk("rst_ctrl", {57'd0, mem_we, m1_rvalid, m0_rvalid, m1_gnt, m0_gnt}, 64'd0);
      chk("rst_addr_wdata", {mem_addr, mem_wdata}, 64'd0);
      chk("rst_rdata", {m1_rdata, m0_rdata}, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      tick();

      // Table-driven single-requester accesses, chained back-to-back.
      for (int i = 0; i < 8; i++) do_access(vecs[i]);

      // Reset during ACCESS of a word write.
      m0_req = 1'b1; m0_we = 3'b001; m0_addr = 32'h300; m0_wdata = 32'h1111_1111;
      tick();
      chk("mid_rst_pre_we", {61'd0, mem_we}, 64'd1);
      #2 rst = 1'b1;
      #1;
      exp_rd0 = 32'h0; exp_rd1 = 32'h0;
      chk("mid_rst_async", {59'd0, mem_we, m1_gnt, m0_gnt}, 64'd0);
      chk("mid_rst_rdata", {m1_rdata, m0_rdata}, 64'd0);
      m0_req = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      tick();

      // Both ports held: tie goes to port 0 after reset, then strict alternation.
      m0_req = 1'b1; m0_we = 3'b000; m0_addr = 32'h100;
      m1_req = 1'b1; m1_we = 3'b000; m1_addr = 32'h204;
      for (int c = 1; c <= 24; c++) begin
         logic [3:0] e;
         tick();
         e = {(c % 6 == 0), (c % 6 == 3), (c % 6 == 4), (c % 6 == 1)};
         chk($sformatf("both_c%0d", c), {60'd0, m1_rvalid, m0_rvalid, m1_gnt, m0_gnt}, {60'd0, e});
         if (e[0]) chk("both_addr0", {32'd0, mem_addr}, 64'h100);
         if (e[1]) chk("both_addr1", {32'd0, mem_addr}, 64'h204);
         if (e[2]) chk("both_rd0", {32'd0, m0_rdata}, 64'hDEAD_BEEF);
         if (e[3]) chk("both_rd1", {32'd0, m1_rdata}, 64'hA5A5_00CC);
         if (c == 22) begin m0_req = 1'b0; m1_req = 1'b0; end
      end

      // Port 0 continuous; port 1 joins during port 0's ACCESS and wins next.
      m0_req = 1'b1; m0_addr = 32'h100;
      m1_addr = 32'h200;
      for (int c = 1; c <= 9; c++) begin
         logic [3:0] e;
         tick();
         e = {(c == 6), (c == 3 || c == 9), (c == 4), (c == 1 || c == 7)};
         chk($sformatf("mid_c%0d", c), {60'd0, m1_rvalid, m0_rvalid, m1_gnt, m0_gnt}, {60'd0, e});
         if (c == 1) m1_req = 1'b1;
         if (c == 4) m1_req = 1'b0;
         if (c == 7) m0_req = 1'b0;
      end
      exp_rd0 = 32'hDEAD_BEEF;
      exp_rd1 = 32'hA5A5_0080;

      // The write interrupted by reset must not have reached memory.
      do_access(rd300);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
